// File: rtl/write_controller_pkg.sv
// Shared packet bus types and constants for the register write endpoint.
package write_controller_pkg;

  localparam logic [7:0]  READ_DEST  = 8'h00;
  localparam logic [7:0]  WRITE_DEST = 8'h01;
  localparam int unsigned DATA_BYTES = 4;

  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic       SoP;
    logic       EoP;
    logic       Valid;
    logic [7:0] Data;
  } UART_PACKET;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_DISCARD,
    ST_COMMIT,
    ST_ACK
  } wc_state_e;

endpackage

// File: rtl/write_controller.sv
// Register write endpoint: assembles address + little-endian data word from the rx stream.
// WRITE_CONTROLLER_ACK_EN adds a one-byte acknowledge packet on opTxStream.
module write_controller
  import write_controller_pkg::*;
(
  input  logic                    ipClk,
  input  logic                    ipReset,
  input  UART_PACKET              ipRxStream,
  output logic [7:0]              opWrAddress,
  output logic [8*DATA_BYTES-1:0] opWrData,
  output logic                    opWrEnable,
  output logic                    opError,
  output UART_PACKET              opTxStream,
  input  logic                    ipTxReady
);

  localparam int unsigned         CNT_W    = $clog2(DATA_BYTES);
  localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(DATA_BYTES - 1);

  wc_state_e                 state_q, state_d;
  logic [7:0]                addr_q, addr_d;
  logic [7:0]                src_q, src_d;
  logic [8*DATA_BYTES-1:0]   word_q, word_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [7:0]                wr_addr_q, wr_addr_d;
  logic [8*DATA_BYTES-1:0]   wr_data_q, wr_data_d;
  logic                      wr_en_q, wr_en_d;
  logic                      err_q, err_d;
  logic                      is_write_sop;

  assign is_write_sop = ipRxStream.Valid && ipRxStream.SoP &&
                        (ipRxStream.Destination == WRITE_DEST);

`ifdef WRITE_CONTROLLER_ACK_EN
  UART_PACKET tx_q, tx_d;
  logic       unused_bits;
  assign unused_bits = ^ipRxStream.Length;
  assign opTxStream  = tx_q;
`else
  logic       unused_bits;
  assign unused_bits = ^{ipRxStream.Length, ipTxReady, src_q};
  assign opTxStream  = '0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    src_d     = src_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    err_d     = 1'b0;
`ifdef WRITE_CONTROLLER_ACK_EN
    tx_d      = tx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (is_write_sop) begin
          addr_d  = ipRxStream.Data;
          src_d   = ipRxStream.Source;
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (ipRxStream.Valid) begin
          if (ipRxStream.SoP) begin
            // A new start mid-request aborts the old one; a write SoP becomes the new address.
            err_d = 1'b1;
            if (is_write_sop) begin
              addr_d = ipRxStream.Data;
              src_d  = ipRxStream.Source;
              cnt_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            word_d[{cnt_q, 3'b000} +: 8] = ipRxStream.Data;
            if (cnt_q == LAST_IDX) begin
              if (ipRxStream.EoP) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = word_d;
                state_d   = ST_COMMIT;
              end else begin
                err_d   = 1'b1;
                state_d = ST_DISCARD;
              end
            end else if (ipRxStream.EoP) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      ST_DISCARD: begin
        if (ipRxStream.Valid && ipRxStream.EoP) begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
`ifdef WRITE_CONTROLLER_ACK_EN
        tx_d.Source      = WRITE_DEST;
        tx_d.Destination = src_q;
        tx_d.Length      = 8'd1;
        tx_d.SoP         = 1'b1;
        tx_d.EoP         = 1'b1;
        tx_d.Valid       = 1'b1;
        tx_d.Data        = addr_q;
        state_d          = ST_ACK;
`else
        state_d = ST_IDLE;
`endif
      end
`ifdef WRITE_CONTROLLER_ACK_EN
      ST_ACK: begin
        if (ipTxReady) begin
          tx_d    = '0;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      src_q     <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef WRITE_CONTROLLER_ACK_EN
      tx_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      src_q     <= src_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      err_q     <= err_d;
`ifdef WRITE_CONTROLLER_ACK_EN
      tx_q      <= tx_d;
`endif
    end
  end

  assign opWrAddress = wr_addr_q;
  assign opWrData    = wr_data_q;
  assign opWrEnable  = wr_en_q;
  assign opError     = err_q;

endmodule

// File: tb/tb_write_controller.sv
// Directed bench for write_controller; inputs driven and outputs sampled on the falling edge.
module tb_write_controller;
  import write_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  UART_PACKET  rx;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        err;
  UART_PACKET  tx;
  logic        ready;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned wr_pulses = 0;
  int unsigned err_pulses = 0;
  int unsigned tx_valid_cycles = 0;
  int unsigned prev_wr_cyc = 0;
  int unsigned last_wr_cyc = 0;
  int unsigned w0, e0;

  write_controller dut (
    .ipClk       (clk),
    .ipReset     (rst),
    .ipRxStream  (rx),
    .opWrAddress (wr_addr),
    .opWrData    (wr_data),
    .opWrEnable  (wr_en),
    .opError     (err),
    .opTxStream  (tx),
    .ipTxReady   (ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && wr_en) begin
      wr_pulses   <= wr_pulses + 1;
      prev_wr_cyc <= last_wr_cyc;
      last_wr_cyc <= cyc;
    end
    if (!rst && err) err_pulses <= err_pulses + 1;
    if (!rst && tx.Valid) tx_valid_cycles <= tx_valid_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] src, input logic [7:0] dst,
                      input logic sop, input logic eop, input logic [7:0] d);
    rx = '{Source: src, Destination: dst, Length: 8'd5,
           SoP: sop, EoP: eop, Valid: 1'b1, Data: d};
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    rx = '0;
    repeat (n) @(negedge clk);
  endtask

  // Leaves the caller at the falling edge of the cycle after the last byte (the commit cycle).
  task automatic request(input logic [7:0] src, input logic [7:0] addr, input logic [31:0] w);
    send(src, WRITE_DEST, 1'b1, 1'b0, addr);
    for (int i = 0; i < 4; i++) send(src, WRITE_DEST, 1'b0, (i == 3), w[i*8 +: 8]);
  endtask

  initial begin
    rx    = '0;
    ready = 1'b1;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_addr", wr_addr, 0);
    check_eq("rst_data", wr_data, 0);
    check_eq("rst_en", wr_en, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_tx", tx, 0);
    rst = 1'b0;
    idle(1);

    // basic write: address 0x11, data 00 10 20 30
`ifdef WRITE_CONTROLLER_ACK_EN
    ready = 1'b0;
`endif
    request(8'h00, 8'h11, 32'h30201000);
    check_eq("t1_en", wr_en, 1);
    check_eq("t1_addr", wr_addr, 8'h11);
    check_eq("t1_data", wr_data, 32'h30201000);
    idle(1);
    check_eq("t1_en_off", wr_en, 0);
    check_eq("t1_addr_hold", wr_addr, 8'h11);
    check_eq("t1_data_hold", wr_data, 32'h30201000);
`ifdef WRITE_CONTROLLER_ACK_EN
    check_eq("ack_src", tx.Source, 8'h01);
    check_eq("ack_dst", tx.Destination, 8'h00);
    check_eq("ack_data", tx.Data, 8'h11);
    check_eq("ack_len", tx.Length, 8'd1);
    check_eq("ack_sop_eop", {tx.SoP, tx.EoP}, 2'b11);
    for (int k = 1; k <= 4; k++) begin
      check_eq("ack_valid_held", tx.Valid, 1);
      if (k == 4) ready = 1'b1;
      @(negedge clk);
    end
    check_eq("ack_cleared", tx, 0);
    check_eq("ack_cycles", tx_valid_cycles, 4);
`else
    check_eq("t1_tx_zero", tx, 0);
`endif
    idle(2);

    // packet to the read destination is ignored
    w0 = wr_pulses; e0 = err_pulses;
    send(8'h00, READ_DEST, 1'b1, 1'b0, 8'h99);
    for (int i = 0; i < 4; i++) send(8'h00, READ_DEST, 1'b0, (i == 3), 8'h55);
    idle(3);
    check_eq("rd_no_wr", wr_pulses - w0, 0);
    check_eq("rd_no_err", err_pulses - e0, 0);
    check_eq("rd_addr_hold", wr_addr, 8'h11);

    // early EoP: error pulse, no write, next request fine
    w0 = wr_pulses; e0 = err_pulses;
    send(8'h00, WRITE_DEST, 1'b1, 1'b0, 8'h22);
    send(8'h00, WRITE_DEST, 1'b0, 1'b0, 8'hAA);
    send(8'h00, WRITE_DEST, 1'b0, 1'b1, 8'hBB);
    check_eq("eop_err", err, 1);
    idle(1);
    check_eq("eop_err_pulse", err, 0);
    request(8'h5A, 8'h44, 32'hEFBEADDE);
    check_eq("eop_next_addr", wr_addr, 8'h44);
    check_eq("eop_next_data", wr_data, 32'hEFBEADDE);
    idle(4);
    check_eq("eop_wr_cnt", wr_pulses - w0, 1);
    check_eq("eop_err_cnt", err_pulses - e0, 1);

    // missing EoP on last byte: discard to EoP, no write
    w0 = wr_pulses; e0 = err_pulses;
    send(8'h00, WRITE_DEST, 1'b1, 1'b0, 8'h66);
    for (int i = 0; i < 4; i++) send(8'h00, WRITE_DEST, 1'b0, 1'b0, 8'h01);
    check_eq("disc_err", err, 1);
    send(8'h00, WRITE_DEST, 1'b1, 1'b0, 8'h77);
    send(8'h00, WRITE_DEST, 1'b0, 1'b1, 8'h00);
    idle(2);
    check_eq("disc_no_wr", wr_pulses - w0, 0);
    check_eq("disc_addr_hold", wr_addr, 8'h44);
    request(8'h00, 8'h12, 32'h0BADF00D);
    check_eq("disc_next_addr", wr_addr, 8'h12);
    check_eq("disc_next_data", wr_data, 32'h0BADF00D);
    idle(4);

    // SoP mid-request restarts with the new address
    e0 = err_pulses;
    send(8'h00, WRITE_DEST, 1'b1, 1'b0, 8'h70);
    send(8'h00, WRITE_DEST, 1'b0, 1'b0, 8'hFF);
    request(8'h00, 8'h71, 32'hA1B2C3D4);
    check_eq("restart_addr", wr_addr, 8'h71);
    check_eq("restart_data", wr_data, 32'hA1B2C3D4);
    idle(4);
    check_eq("restart_err", err_pulses - e0, 1);

    // reset mid-request
    w0 = wr_pulses;
    send(8'h00, WRITE_DEST, 1'b1, 1'b0, 8'h55);
    send(8'h00, WRITE_DEST, 1'b0, 1'b0, 8'hAA);
    send(8'h00, WRITE_DEST, 1'b0, 1'b0, 8'hBB);
    rst = 1'b1;
    idle(1);
    check_eq("mrst_addr", wr_addr, 0);
    check_eq("mrst_data", wr_data, 0);
    check_eq("mrst_en", wr_en, 0);
    rst = 1'b0;
    send(8'h00, WRITE_DEST, 1'b0, 1'b0, 8'hCC);
    send(8'h00, WRITE_DEST, 1'b0, 1'b1, 8'hDD);
    idle(2);
    check_eq("mrst_no_wr", wr_pulses - w0, 0);
    request(8'h00, 8'h33, 32'h04030201);
    check_eq("mrst_next_addr", wr_addr, 8'h33);
    check_eq("mrst_next_data", wr_data, 32'h04030201);
    idle(4);

    // back-to-back requests
    request(8'h00, 8'hA0, 32'h44332211);
    check_eq("b2b_1_addr", wr_addr, 8'hA0);
    check_eq("b2b_1_data", wr_data, 32'h44332211);
`ifdef WRITE_CONTROLLER_ACK_EN
    idle(2);
`else
    idle(1);
`endif
    request(8'h00, 8'hA1, 32'h88776655);
    check_eq("b2b_2_addr", wr_addr, 8'hA1);
    check_eq("b2b_2_data", wr_data, 32'h88776655);
    idle(2);
`ifdef WRITE_CONTROLLER_ACK_EN
    check_eq("b2b_spacing", last_wr_cyc - prev_wr_cyc, 7);
`else
    check_eq("b2b_spacing", last_wr_cyc - prev_wr_cyc, 6);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
